// File: rtl/led_fx_pkg.sv
// led_fx_pkg: shared types and constants for the LED effects driver.
//   mode_e      - effect mode encodings (also the FSM state encoding)
//   ADDR_*      - control register addresses on the fx bus
//   rotl16      - 16-bit rotate-left helper used by the marquee
package led_fx_pkg;

  localparam int LED_W     = 16;
  localparam int NUM_BANKS = 2;
  localparam int BANK_W    = LED_W / NUM_BANKS;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'b00,
    MODE_BLINK  = 2'b01,
    MODE_SHIFT  = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;

  localparam logic [1:0] ADDR_DUTY = 2'b01;
  localparam logic [1:0] ADDR_MASK = 2'b10;
  localparam logic [1:0] ADDR_MODE = 2'b11;

  function automatic logic [LED_W-1:0] rotl16(input logic [LED_W-1:0] v,
                                              input logic [3:0]       sh);
    logic [2*LED_W-1:0] w;
    w = {v, v} << sh;
    return w[2*LED_W-1:LED_W];
  endfunction

endpackage

// File: rtl/led_fx_if.sv
// led_fx_if: control register write bus from the MMIO decoder.
//   fxcs    - chip select, a write happens on every edge it is high
//   fxaddr  - register select
//   fxwdata - write data
interface led_fx_if;
  logic        fxcs;
  logic [1:0]  fxaddr;
  logic [15:0] fxwdata;

  modport master (output fxcs, output fxaddr, output fxwdata);
  modport slave  (input  fxcs, input  fxaddr, input  fxwdata);
endinterface

// File: rtl/led_fx_tick.sv
// led_fx_tick: effect tick divider.
//   i_clk/i_rst_n - clock, async active-low reset
//   i_clr         - synchronous clear of the divider (mode write)
//   o_tick        - high for the one cycle the count sits at TICK_DIV-1;
//                   suppressed when a clear lands in the same cycle
module led_fx_tick #(
  parameter int TICK_DIV = 11_500_000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  output logic o_tick
);
  localparam int          W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] r_cnt;
  logic         w_last;

  assign w_last = (r_cnt == LAST);
  assign o_tick = w_last && !i_clr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)              r_cnt <= '0;
    else if (i_clr || w_last)  r_cnt <= '0;
    else                       r_cnt <= r_cnt + W'(1);
  end
endmodule

// File: rtl/led_fx_driver.sv
// led_fx_driver: applies per-bank PWM dimming, masked blinking or a rotating
// marquee to the CPU-latched LED value.
//   led_clk/ledrst - clock, async active-low reset
//   ledin          - value held by the LED output register
//   fx_bus         - control register writes (duty, blink mask, mode)
//   led_pin        - registered board LED drive
//   fx_mode        - current mode, for readback
module led_fx_driver
  import led_fx_pkg::*;
#(
  parameter int PWM_BITS = 4,
  parameter int TICK_DIV = 11_500_000
) (
  input  logic             led_clk,
  input  logic             ledrst,
  input  logic [LED_W-1:0] ledin,
  led_fx_if.slave          fx_bus,
  output logic [LED_W-1:0] led_pin,
  output logic [1:0]       fx_mode
);

  logic w_wr_duty, w_wr_mask, w_wr_mode, w_tick;
  mode_e r_mode, w_mode_nxt;

  logic [NUM_BANKS-1:0][PWM_BITS-1:0] r_duty;
  logic [PWM_BITS-1:0]                r_pwmcnt;
  logic [LED_W-1:0]                   r_mask, r_led_pin, w_base, w_gate;
  logic [3:0]                         r_offset;
  logic                               r_phase;
  logic [NUM_BANKS-1:0]               w_bank_on;

  assign w_wr_duty = fx_bus.fxcs && (fx_bus.fxaddr == ADDR_DUTY);
  assign w_wr_mask = fx_bus.fxcs && (fx_bus.fxaddr == ADDR_MASK);
  assign w_wr_mode = fx_bus.fxcs && (fx_bus.fxaddr == ADDR_MODE);

  // Mode write clears the divider, so a tick colliding with it is dropped.
  led_fx_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .i_clk   (led_clk),
    .i_rst_n (ledrst),
    .i_clr   (w_wr_mode),
    .o_tick  (w_tick)
  );

  // Mode FSM: only a mode register write moves it.
  always_ff @(posedge led_clk or negedge ledrst) begin
    if (!ledrst) r_mode <= MODE_STATIC;
    else         r_mode <= w_mode_nxt;
  end

  always_comb begin
    w_mode_nxt = r_mode;
    if (w_wr_mode) w_mode_nxt = mode_e'(fx_bus.fxwdata[1:0]);
  end

  // Reserved mode falls through to pass-through.
  always_comb begin
    w_base = ledin;
    case (r_mode)
      MODE_BLINK: w_base = ledin & ~(r_mask & {LED_W{~r_phase}});
      MODE_SHIFT: w_base = rotl16(ledin, r_offset);
      default:    w_base = ledin;
    endcase
  end

  // All-ones duty is forced fully on; otherwise lit while pwmcnt < duty.
  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    assign w_bank_on[g] = (&r_duty[g]) || (r_pwmcnt < r_duty[g]);
    assign w_gate[g*BANK_W +: BANK_W] = {BANK_W{w_bank_on[g]}};
  end

  always_ff @(posedge led_clk or negedge ledrst) begin
    if (!ledrst) begin
      r_duty    <= '1;
      r_mask    <= '0;
      r_pwmcnt  <= '0;
      r_phase   <= 1'b1;
      r_offset  <= '0;
      r_led_pin <= '0;
    end else begin
      r_pwmcnt <= r_pwmcnt + PWM_BITS'(1);
      if (w_wr_duty)
        for (int b = 0; b < NUM_BANKS; b++)
          r_duty[b] <= fx_bus.fxwdata[b*PWM_BITS +: PWM_BITS];
      if (w_wr_mask) r_mask <= fx_bus.fxwdata;
      if (w_wr_mode) begin
        r_phase  <= 1'b1;
        r_offset <= '0;
      end else if (w_tick) begin
        if (r_mode == MODE_BLINK) r_phase  <= ~r_phase;
        if (r_mode == MODE_SHIFT) r_offset <= r_offset + 4'd1;
      end
      r_led_pin <= w_base & w_gate;
    end
  end

  assign led_pin = r_led_pin;
  assign fx_mode = r_mode;

endmodule

// File: tb/tb_led_fx_driver.sv
module tb_led_fx_driver;
  import led_fx_pkg::*;

  logic        led_clk = 1'b0;
  logic        ledrst;
  logic [15:0] ledin;
  logic [15:0] led_pin;
  logic [1:0]  fx_mode;
  int          checks   = 0;
  int          failures = 0;

  led_fx_if fx_bus();

  led_fx_driver #(.PWM_BITS(4), .TICK_DIV(4)) dut (
    .led_clk (led_clk),
    .ledrst  (ledrst),
    .ledin   (ledin),
    .fx_bus  (fx_bus),
    .led_pin (led_pin),
    .fx_mode (fx_mode)
  );

  always #5 led_clk = ~led_clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge led_clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    fx_bus.fxcs    = 1'b1;
    fx_bus.fxaddr  = a;
    fx_bus.fxwdata = d;
    step();
    fx_bus.fxcs    = 1'b0;
    fx_bus.fxaddr  = 2'b00;
    fx_bus.fxwdata = 16'h0000;
  endtask

  task automatic test_reset();
    ledin  = 16'hA5C3;
    #2 ledrst = 1'b0;
    #1;
    checks++;
    if (led_pin !== 16'h0000 || fx_mode !== 2'b00) begin
      failures++;
      $display("FAIL reset_state led_pin=%h fx_mode=%0d want 0000/0", led_pin, fx_mode);
    end
    step();
    ledrst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (led_pin !== 16'hA5C3 || fx_mode !== 2'b00) begin
        failures++;
        $display("FAIL passthru k=%0d led_pin=%h fx_mode=%0d want A5C3/0", k, led_pin, fx_mode);
      end
    end
  endtask

  task automatic test_dimming();
    int lit;
    lit   = 0;
    ledin = 16'hFFFF;
    wr(ADDR_DUTY, 16'h0040);
    step();
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (led_pin[7:0] !== 8'h00 || (led_pin[15:8] !== 8'hFF && led_pin[15:8] !== 8'h00)) begin
        failures++;
        $display("FAIL dim_shape k=%0d led_pin=%h want lo=00 hi=00/FF", k, led_pin);
      end
      if (led_pin[15:8] === 8'hFF) lit++;
      step();
    end
    checks++;
    if (lit != 4) begin
      failures++;
      $display("FAIL dim_duty hi_lit_cycles=%0d want 4", lit);
    end
    wr(ADDR_DUTY, 16'h00FF);
  endtask

  task automatic test_blink();
    logic [15:0] exp;
    ledin = 16'h00FF;
    wr(ADDR_MASK, 16'h000F);
    wr(ADDR_MODE, 16'h0001);
    step();
    checks++;
    if (fx_mode !== 2'b01) begin
      failures++;
      $display("FAIL blink_mode fx_mode=%0d want 1", fx_mode);
    end
    for (int k = 0; k < 16; k++) begin
      exp = (((k / 4) % 2) == 0) ? 16'h00FF : 16'h00F0;
      checks++;
      if (led_pin !== exp) begin
        failures++;
        $display("FAIL blink k=%0d led_pin=%h want %h", k, led_pin, exp);
      end
      step();
    end
  endtask

  task automatic test_marquee();
    logic [15:0] exp;
    logic [15:0] one;
    one   = 16'h0001;
    ledin = 16'h0001;
    wr(ADDR_MODE, 16'h0002);
    step();
    for (int k = 0; k < 68; k++) begin
      exp = one << ((k / 4) % 16);
      checks++;
      if (led_pin !== exp) begin
        failures++;
        $display("FAIL marquee k=%0d led_pin=%h want %h", k, led_pin, exp);
      end
      step();
    end
  endtask

  task automatic test_collision();
    logic [15:0] exp;
    ledin = 16'h0001;
    wr(ADDR_MODE, 16'h0002);
    step();
    step();
    step();
    // divider is now at its last count: this write lands on the tick
    wr(ADDR_MODE, 16'h0002);
    for (int k = 0; k < 6; k++) begin
      step();
      exp = (k < 4) ? 16'h0001 : 16'h0002;
      checks++;
      if (led_pin !== exp) begin
        failures++;
        $display("FAIL collision k=%0d led_pin=%h want %h", k, led_pin, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    ledin = 16'h0001;
    wr(ADDR_MODE, 16'h0002);
    for (int k = 0; k < 29; k++) step();
    checks++;
    if (led_pin !== 16'h0080) begin
      failures++;
      $display("FAIL mid_offset7 led_pin=%h want 0080", led_pin);
    end
    ledrst = 1'b0;
    #1;
    checks++;
    if (led_pin !== 16'h0000 || fx_mode !== 2'b00) begin
      failures++;
      $display("FAIL mid_reset led_pin=%h fx_mode=%0d want 0000/0", led_pin, fx_mode);
    end
    step();
    ledin  = 16'hFFFF;
    ledrst = 1'b1;
    for (int k = 0; k < 16; k++) begin
      step();
      checks++;
      if (led_pin !== 16'hFFFF || fx_mode !== 2'b00) begin
        failures++;
        $display("FAIL post_reset k=%0d led_pin=%h fx_mode=%0d want FFFF/0", k, led_pin, fx_mode);
      end
    end
    wr(ADDR_MODE, 16'h0001);
    for (int k = 0; k < 8; k++) begin
      step();
      checks++;
      if (led_pin !== 16'hFFFF || fx_mode !== 2'b01) begin
        failures++;
        $display("FAIL post_reset_mask k=%0d led_pin=%h fx_mode=%0d want FFFF/1", k, led_pin, fx_mode);
      end
    end
  endtask

  task automatic test_reserved();
    ledin = 16'h1234;
    wr(ADDR_MODE, 16'h0003);
    for (int k = 0; k < 6; k++) begin
      step();
      checks++;
      if (led_pin !== 16'h1234 || fx_mode !== 2'b11) begin
        failures++;
        $display("FAIL reserved k=%0d led_pin=%h fx_mode=%0d want 1234/3", k, led_pin, fx_mode);
      end
    end
  endtask

  initial begin
    ledrst         = 1'b1;
    ledin          = 16'h0000;
    fx_bus.fxcs    = 1'b0;
    fx_bus.fxaddr  = 2'b00;
    fx_bus.fxwdata = 16'h0000;
    test_reset();
    test_dimming();
    test_blink();
    test_marquee();
    test_collision();
    test_reset_mid();
    test_reserved();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
